// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// Each granted command runs IDLE -> EXEC -> RESP and returns a tagged, registered result.
module alu_arbiter #(
  parameter int unsigned     WIDTH      = 8,
  parameter int unsigned     OPW        = 3,
  parameter logic [OPW-1:0]  ERR_OPCODE = 3'b111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_opcode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_opcode,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e             state_q;
  logic               prio_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [OPW-1:0]     op_q;
  logic               id_q;
  logic               resp_valid_q, resp_id_q, resp_err_q;
  logic [WIDTH-1:0]   resp_data_q;
  logic               grant0, grant1;

  // Pointer only matters when both requesters are valid in the same cycle.
  always_comb begin
    grant0 = (state_q == StIdle) && req0_valid && (!req1_valid || !prio_q);
    grant1 = (state_q == StIdle) && req1_valid && (!req0_valid ||  prio_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      prio_q       <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant0 || grant1) begin
            a_q     <= grant1 ? req1_a      : req0_a;
            b_q     <= grant1 ? req1_b      : req0_b;
            op_q    <= grant1 ? req1_opcode : req0_opcode;
            id_q    <= grant1;
            state_q <= StExec;
          end
        end
        StExec: begin
          resp_data_q  <= alu_result;
          resp_err_q   <= (op_q == ERR_OPCODE);
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            prio_q       <= ~resp_id_q;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU standing in for the external one.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_opcode, req1_opcode;
  logic       resp_valid, resp_ready, resp_id, resp_err, busy;
  logic [7:0] resp_data, alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_opcode(req1_opcode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_err(resp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .busy(busy)
  );

  // External ALU: 8-bit results, opcode 111 unsupported and returns 0.
  always_comb begin
    alu_result = 8'h00;
    case (alu_opcode)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = alu_a ^ alu_b;
      3'b101:  alu_result = ~alu_a;
      3'b110:  alu_result = alu_a * alu_b;
      default: alu_result = 8'h00;
    endcase
  end

  // Mutual exclusion of the two ready signals, checked every cycle out of reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      assert (!(req0_ready === 1'b1 && req1_ready === 1'b1)) else begin
        bad++;
        $error("FAIL both_ready observed=%b%b expected=not 11", req0_ready, req1_ready);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One request from a single requester, drained with resp_ready pulsed.
  task automatic txn(input string tag, input logic who, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] op, input logic [7:0] exp_data, input logic exp_err);
    if (who) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_opcode = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_opcode = op;
    end
    #1;
    chk({tag, "_ready"}, who ? req1_ready : req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk({tag, "_exec_busy"}, busy, 1'b1);
    chk({tag, "_exec_alu_a"}, alu_a, a);
    chk({tag, "_exec_nvalid"}, resp_valid, 1'b0);
    tick();
    chk({tag, "_valid"}, resp_valid, 1'b1);
    chk({tag, "_id"}, resp_id, who);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, resp_err, exp_err);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk({tag, "_done_valid"}, resp_valid, 1'b0);
    chk({tag, "_done_busy"}, busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_opcode = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_opcode = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_resp_id", resp_id, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_data", resp_data, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_opcode", alu_opcode, 3'b000);
    chk("rst_ready0", req0_ready, 1'b0);
    rst = 1'b0;

    txn("single", 1'b0, 8'h12, 8'h34, 3'b000, 8'h46, 1'b0);

    // Fairness: both always valid, consumer always ready.
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_opcode = 3'b001;
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h0F; req1_opcode = 3'b011;
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_ready0", i), req0_ready, (i % 2) == 0);
      chk($sformatf("rr%0d_ready1", i), req1_ready, (i % 2) == 1);
      tick();
      chk($sformatf("rr%0d_exec_ready0", i), req0_ready, 1'b0);
      tick();
      chk($sformatf("rr%0d_id", i), resp_id, (i % 2) == 1);
      chk($sformatf("rr%0d_data", i), resp_data, (i % 2) ? 8'hFF : 8'h02);
      chk($sformatf("rr%0d_valid", i), resp_valid, 1'b1);
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    tick();

    // Back-pressure: response held for 5 cycles with both requesters clamoring.
    do_reset();
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F; req0_opcode = 3'b010;
    tick();
    req1_valid = 1'b1; req1_a = 8'h11; req1_b = 8'h22; req1_opcode = 3'b000;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp%0d_valid", i), resp_valid, 1'b1);
      chk($sformatf("bp%0d_data", i), resp_data, 8'h0C);
      chk($sformatf("bp%0d_id", i), resp_id, 1'b0);
      chk($sformatf("bp%0d_err", i), resp_err, 1'b0);
      chk($sformatf("bp%0d_busy", i), busy, 1'b1);
      chk($sformatf("bp%0d_ready0", i), req0_ready, 1'b0);
      chk($sformatf("bp%0d_ready1", i), req1_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("bp_release_busy", busy, 1'b0);
    chk("bp_release_valid", resp_valid, 1'b0);
    chk("bp_next_ready1", req1_ready, 1'b1);
    chk("bp_next_ready0", req0_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    txn("errop", 1'b0, 8'hAA, 8'h55, 3'b111, 8'h00, 1'b1);
    txn("mulwrap", 1'b0, 8'h10, 8'h10, 3'b110, 8'h00, 1'b0);
    txn("addwrap", 1'b0, 8'hFF, 8'h01, 3'b000, 8'h00, 1'b0);

    // Reset during EXEC (pointer currently favours requester 1).
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_opcode = 3'b000;
    tick();
    req0_valid = 1'b0;
    chk("rstx_in_exec", busy, 1'b1);
    do_reset();
    chk("rstx_valid", resp_valid, 1'b0);
    chk("rstx_busy", busy, 1'b0);
    tick();
    chk("rstx_no_resp", resp_valid, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rstx_ready0", req0_ready, 1'b1);
    chk("rstx_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Reset during RESP after pushing the pointer back to requester 1.
    txn("pre_rstr", 1'b0, 8'h07, 8'h01, 3'b001, 8'h06, 1'b0);
    req0_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("rstr_in_resp", resp_valid, 1'b1);
    do_reset();
    chk("rstr_valid", resp_valid, 1'b0);
    chk("rstr_busy", busy, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rstr_ready0", req0_ready, 1'b1);
    chk("rstr_ready1", req1_ready, 1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Serving requester 1 alone hands priority to requester 0.
    txn("pp_r0", 1'b0, 8'h0F, 8'hF0, 3'b100, 8'hFF, 1'b0);
    txn("pp_r1", 1'b1, 8'hF0, 8'h3C, 3'b100, 8'hCC, 1'b0);
    req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h00; req0_opcode = 3'b101;
    req1_valid = 1'b1;
    #1;
    chk("pp_ready0", req0_ready, 1'b1);
    chk("pp_ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("pp_resp_id", resp_id, 1'b0);
    chk("pp_resp_data", resp_data, 8'hA5);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 8-bit ALU between two requesters, each presenting operands A/B and a 3-bit opcode.
- Grants requesters round-robin and drives the ALU from registered operands.
- Captures the ALU result and returns it on a shared response channel tagged with the requester id.
- Sits between the requester front-ends and the ALU instance; the ALU itself stays external.

Parameters:
- WIDTH, 8, operand/result width in bits.
- OPW, 3, opcode width in bits.
- ERR_OPCODE, 3'b111, opcode value flagged as unsupported (the ALU returns 0 for it).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_ready  output  1  requester 0 command accepted this cycle.
- req0_a  input  WIDTH  requester 0 operand A.
- req0_b  input  WIDTH  requester 0 operand B.
- req0_opcode  input  OPW  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_opcode: same as requester 0, for requester 1.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  1  requester that owns the response.
- resp_data  output  WIDTH  captured ALU result.
- resp_err  output  1  latched opcode == ERR_OPCODE.
- alu_a  output  WIDTH  operand A to ALU.
- alu_b  output  WIDTH  operand B to ALU.
- alu_opcode  output  OPW  opcode to ALU.
- alu_result  input  WIDTH  ALU combinational output.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On reset:
  - state=IDLE; priority pointer=0 (requester 0 favoured).
  - All operand, opcode and result registers = 0.
  - resp_valid=0, resp_id=0, resp_err=0, busy=0; req0_ready=req1_ready=0.
  - Reset mid-transaction drops the in-flight command silently; no response is produced.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is combinational. It is high only for the winning requester, and only while its reqN_valid=1. Both ready signals are never high together.
  - Winner selection: if only one requester is valid, it wins. If both are valid, the requester named by the priority pointer wins.
  - On the handshake edge, latch a/b/opcode/id from the winner and go to EXEC.
  - If neither requester is valid, stay in IDLE.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_opcode are driven from the latched registers at all times. They hold their last value outside EXEC.
  - At the end of the cycle, capture alu_result into resp_data, set resp_err = (latched opcode == ERR_OPCODE), set resp_valid=1, go to RESP.
- RESP:
  - resp_valid, resp_id, resp_data and resp_err hold stable until resp_ready=1.
  - On the resp_ready edge: clear resp_valid, set priority pointer = ~resp_id, return to IDLE.
  - A new request may be accepted no earlier than the cycle after the response handshake (no IDLE bypass).
- Latency: request handshake at edge k -> resp_valid high after edge k+1. Minimum 3 cycles per transaction with resp_ready tied high.
- Requesters are not ready outside IDLE. A requester that drops valid before being granted loses nothing; no queuing is done.
- Arithmetic:
  - No width changes. The result is exactly WIDTH bits of alu_result, so overflow and carry are truncated by the ALU.
  - resp_err is informational only; resp_data still carries alu_result (0 for ERR_OPCODE).
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1...

Test Plan:
- Reset then single request: req0 valid with a=8'h12, b=8'h34, opcode=000 -> req0_ready in cycle 0; resp_valid after 2 edges with resp_id=0, resp_data=8'h46, resp_err=0.
- Both requesters continuously valid, resp_ready=1:
  - req0 = (8'h05, 8'h03, 001), req1 = (8'hF0, 8'h0F, 011).
  - Grants alternate 0,1,0,1 over 4 transactions.
  - Responses alternate 8'h02 (id 0) and 8'hFF (id 1).
  - Never both ready high in the same cycle.
- Back-pressure: resp_ready=0 for 5 cycles during RESP -> resp_* held stable, busy=1, both ready signals 0 throughout; releasing resp_ready returns the FSM to IDLE next edge.
- Error and wrap:
  - opcode=111 with a=8'hAA -> resp_data=8'h00, resp_err=1.
  - opcode=110 with a=8'h10, b=8'h10 -> resp_data=8'h00 (truncated), resp_err=0.
  - opcode=000 with a=8'hFF, b=8'h01 -> resp_data=8'h00.
- Reset mid-operation: assert rst during EXEC and separately during RESP -> next cycle resp_valid=0, busy=0, priority pointer=0; a subsequent simultaneous request is granted to requester 0.
- Priority pointer update: req1 alone is served; then both requesters become valid -> requester 0 wins next.
